// File: rtl/perceptron_pkg.sv
// Shared command codes, widths and sequencer state encoding for the
// weighted-sum perceptron slice.
package perceptron_pkg;

    localparam logic [7:0] CMD_LOAD_W = 8'h57;
    localparam logic [7:0] CMD_LOAD_X = 8'h58;
    localparam logic [7:0] CMD_START  = 8'h53;

    localparam int VAL_W = 18;
    localparam int SUM_W = 48;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        WAIT_SUM,
        SEND
    } seq_state_t;

endpackage

// File: rtl/rx_word_assembler.sv
// Packs three big-endian UART bytes into one 18-bit value; word_valid is a
// combinational pulse during the cycle the third byte is presented.
module rx_word_assembler
    import perceptron_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [VAL_W-1:0] word,
    output logic             word_valid
);

    logic [1:0] lane_q;
    logic [1:0] hi_q;
    logic [7:0] mid_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_q <= '0;
            hi_q   <= '0;
            mid_q  <= '0;
        end else if (rx_valid) begin
            case (lane_q)
                2'd0:    begin hi_q  <= rx_data[1:0]; lane_q <= 2'd1; end
                2'd1:    begin mid_q <= rx_data;      lane_q <= 2'd2; end
                default: lane_q <= 2'd0;
            endcase
        end
    end

    // Third byte is used directly so the element lands on the clock it arrives.
    assign word       = {hi_q, mid_q, rx_data};
    assign word_valid = rx_valid && !clear && (lane_q == 2'd2);

endmodule

// File: rtl/weighted_sum_sequencer.sv
// UART command sequencer for weighted_sum_top: loads x/w vectors, waits out
// the datapath latency, then offers the 48-bit sum over a valid/ready handshake.
module weighted_sum_sequencer
    import perceptron_pkg::*;
#(
    parameter int N           = 8,
    parameter int SUM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [VAL_W*N-1:0]   x,
    output logic [VAL_W*N-1:0]   w,
    input  logic [SUM_W-1:0]     sum_in,
    output logic [SUM_W-1:0]     result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 cmd_err,
    output logic                 overrun
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = ($clog2(SUM_LATENCY + 1) > 0) ? $clog2(SUM_LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SUM_LATENCY);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W*N-1:0] x_d, w_d;
    logic [SUM_W-1:0]   result_d;
    logic               result_valid_d, cmd_err_d, overrun_d;
    logic [VAL_W-1:0]   word;
    logic               word_valid;
    logic               asm_clear;

    assign asm_clear = !(state_q == LOAD_W || state_q == LOAD_X);

    rx_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            x            <= '0;
            w            <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            cmd_err      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            x            <= x_d;
            w            <= w_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            cmd_err      <= cmd_err_d;
            overrun      <= overrun_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        x_d            = x;
        w_d            = w;
        result_d       = result;
        result_valid_d = result_valid;
        cmd_err_d      = 1'b0;
        overrun_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD_W: begin state_d = LOAD_W;   idx_d = '0; end
                        CMD_LOAD_X: begin state_d = LOAD_X;   idx_d = '0; end
                        CMD_START:  begin state_d = WAIT_SUM; cnt_d = '0; end
                        default:    cmd_err_d = 1'b1;
                    endcase
                end
            end
            LOAD_W, LOAD_X: begin
                if (word_valid) begin
                    if (state_q == LOAD_W) w_d[int'(idx_q)*VAL_W +: VAL_W] = word;
                    else                   x_d[int'(idx_q)*VAL_W +: VAL_W] = word;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            WAIT_SUM: begin
                overrun_d = rx_valid;
                if (cnt_q == CNT_DONE) begin
                    result_d       = sum_in;
                    result_valid_d = 1'b1;
                    state_d        = SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND: begin
                overrun_d = rx_valid;
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_weighted_sum_sequencer.sv
// Self-checking bench for weighted_sum_sequencer with a behavioural stand-in
// for the weighted_sum_top pipeline and a scoreboard on accepted results.
module tb_weighted_sum_sequencer;
    import perceptron_pkg::*;

    localparam int N           = 8;
    localparam int SUM_LATENCY = 4;
    localparam int VW          = VAL_W * N;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [VW-1:0]     x, w;
    logic [SUM_W-1:0]  sum_in, result;
    logic              result_valid, result_ready, busy, cmd_err, overrun;

    int checks = 0;
    int errors = 0;
    int cmd_err_cnt = 0;
    int overrun_cnt = 0;

    logic [SUM_W-1:0] sb_q[$];
    logic [VW-1:0]    x_m, w_m;
    logic [SUM_W-1:0] sum_pipe [SUM_LATENCY];

    typedef struct {
        logic [17:0] w_val;
        logic [17:0] x_val;
        logic [47:0] exp_sum;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       exp_err;
        logic       exp_busy;
    } byte_vec_t;

    vec_t      vecs [4];
    byte_vec_t bvecs [6];

    always #5 clk = ~clk;

    weighted_sum_sequencer #(.N(N), .SUM_LATENCY(SUM_LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .x            (x),
        .w            (w),
        .sum_in       (sum_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .cmd_err      (cmd_err),
        .overrun      (overrun)
    );

    function automatic logic [SUM_W-1:0] dot(input logic [VW-1:0] xv, input logic [VW-1:0] wv);
        longint acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            logic signed [17:0] a, b;
            a = xv[18*i +: 18];
            b = wv[18*i +: 18];
            acc += longint'(a) * longint'(b);
        end
        return acc[SUM_W-1:0];
    endfunction

    // Stand-in datapath: signed dot product delayed SUM_LATENCY clocks.
    always @(posedge clk) begin
        sum_pipe[0] <= dot(x, w);
        for (int k = 1; k < SUM_LATENCY; k++) sum_pipe[k] <= sum_pipe[k-1];
    end
    assign sum_in = sum_pipe[SUM_LATENCY-1];

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && result_valid === 1'b1 && result_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got result %h with nothing expected", result);
            end else begin
                logic [SUM_W-1:0] e;
                e = sb_q.pop_front();
                check("scoreboard_result", VW'(result), VW'(e));
            end
        end
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (overrun === 1'b1) overrun_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_value(input logic [17:0] v);
        send_byte({6'b0, v[17:16]});
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    task automatic load_uniform(input logic [7:0] cmd, input logic [17:0] v);
        send_byte(cmd);
        for (int i = 0; i < N; i++) begin
            send_value(v);
            if (cmd == CMD_LOAD_W) w_m[18*i +: 18] = v;
            else                   x_m[18*i +: 18] = v;
        end
    endtask

    task automatic start_and_collect(input logic [SUM_W-1:0] exp);
        int k;
        sb_q.push_back(exp);
        send_byte(CMD_START);
        k = 0;
        while (result_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("sum_latency", VW'(k), VW'(SUM_LATENCY + 1));
        tick();
        check("result_valid_cleared", VW'(result_valid), '0);
        check("busy_after_accept", VW'(busy), '0);
    endtask

    initial begin
        logic [SUM_W-1:0] exp5;
        logic [VW-1:0]    x_before;
        int               k, hold_bad, err0, ov0;

        vecs[0] = '{18'd2,      18'd10,     48'd160};
        vecs[1] = '{18'h3FFFF,  18'd5,      48'hFFFF_FFFF_FFD8};
        vecs[2] = '{18'h1FFFF,  18'h1FFFF,  48'h001F_FFE0_0008};
        vecs[3] = '{18'h20000,  18'h20000,  48'h0020_0000_0000};

        bvecs[0] = '{8'h41, 1'b1, 1'b0};
        bvecs[1] = '{8'h00, 1'b1, 1'b0};
        bvecs[2] = '{8'hFF, 1'b1, 1'b0};
        bvecs[3] = '{8'h77, 1'b1, 1'b0};
        bvecs[4] = '{8'h56, 1'b1, 1'b0};
        bvecs[5] = '{8'h59, 1'b1, 1'b0};

        rst          = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        result_ready = 1'b1;
        x_m          = '0;
        w_m          = '0;
        repeat (3) tick();

        check("reset_x", x, '0);
        check("reset_w", w, '0);
        check("reset_result", VW'(result), '0);
        check("reset_flags", VW'({result_valid, busy, cmd_err, overrun}), '0);
        rst = 1'b0;
        tick();

        // Uniform load/compute vectors; row 0 is the w=2, x=10 case.
        for (int r = 0; r < 4; r++) begin
            load_uniform(CMD_LOAD_W, vecs[r].w_val);
            check("busy_after_w_load", VW'(busy), '0);
            check("w_vector", w, {N{vecs[r].w_val}});
            if (r == 0) check("x_untouched", x, '0);
            load_uniform(CMD_LOAD_X, vecs[r].x_val);
            check("x_vector", x, {N{vecs[r].x_val}});
            start_and_collect(vecs[r].exp_sum);
        end

        // Unknown command bytes in IDLE.
        for (int r = 0; r < 6; r++) begin
            err0 = cmd_err_cnt;
            send_byte(bvecs[r].b);
            check("cmd_err_pulse", VW'(cmd_err), VW'(bvecs[r].exp_err));
            check("busy_after_bad_cmd", VW'(busy), VW'(bvecs[r].exp_busy));
            tick();
            check("cmd_err_one_clock", VW'(cmd_err), '0);
            check("cmd_err_count", VW'(cmd_err_cnt - err0), VW'(1));
        end
        start_and_collect(dot(x_m, w_m));

        // Single element with junk in byte0 upper bits, then finish the load.
        x_before = x;
        send_byte(CMD_LOAD_X);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("x0_masked", VW'(x[17:0]), VW'(18'h3FFFF));
        check("x_others_unchanged", VW'(x[VW-1:18]), VW'(x_before[VW-1:18]));
        check("busy_mid_load", VW'(busy), VW'(1));
        x_m[17:0] = 18'h3FFFF;
        for (int i = 1; i < N; i++) send_value(x_m[18*i +: 18]);
        check("busy_after_x_load", VW'(busy), '0);
        check("x_after_partial", x, x_m);
        start_and_collect(dot(x_m, w_m));

        // Consumer stalls in SEND while bytes arrive.
        result_ready = 1'b0;
        exp5 = dot(x_m, w_m);
        sb_q.push_back(exp5);
        send_byte(CMD_START);
        k = 0;
        while (result_valid !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("stall_latency", VW'(k), VW'(SUM_LATENCY + 1));
        ov0      = overrun_cnt;
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 3 || c == 11) begin
                send_byte(CMD_LOAD_W);
                check("overrun_pulse", VW'(overrun), VW'(1));
            end else begin
                tick();
            end
            if (result !== exp5 || result_valid !== 1'b1) hold_bad++;
        end
        check("send_hold_stable", VW'(hold_bad), '0);
        check("overrun_count", VW'(overrun_cnt - ov0), VW'(2));
        result_ready = 1'b1;
        tick();
        check("stall_accept", VW'(result_valid), '0);
        check("stall_idle", VW'(busy), '0);
        check("w_not_loaded_by_overrun", w, w_m);

        // Reset in the middle of a weight load.
        send_byte(CMD_LOAD_W);
        for (int b = 0; b < 5; b++) send_byte(8'h01 + 8'(b));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x_m = '0;
        w_m = '0;
        check("rst_mid_x", x, '0);
        check("rst_mid_w", w, '0);
        check("rst_mid_result", VW'(result), '0);
        check("rst_mid_flags", VW'({result_valid, busy, cmd_err, overrun}), '0);
        send_byte(CMD_LOAD_W);
        for (int i = 0; i < N; i++) begin
            logic [17:0] v;
            v = 18'(i * 3 + 1);
            w_m[18*i +: 18] = v;
            send_byte({6'b0, v[17:16]});
            tick();
            send_byte(v[15:8]);
            tick();
            send_byte(v[7:0]);
        end
        check("reload_w_index0", w, w_m);
        check("reload_idle", VW'(busy), '0);
        load_uniform(CMD_LOAD_X, 18'd7);
        start_and_collect(dot(x_m, w_m));

        check("scoreboard_drained", VW'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
